// File: rtl/regincr_drain_queue.sv
// Credit-managed output queue behind the registered-incrementer pipeline.
// It buffers pipeline results, serves them over val/rdy, returns credits, and latches protocol errors.
module regincr_drain_queue #(
    parameter int nentries = 4,
    parameter int nbits = 8,
    localparam int pw = $clog2(nentries),
    localparam int cw = $clog2(nentries + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue,
    input  logic             in_val,
    input  logic [nbits-1:0] in_,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [nbits-1:0] out,
    output logic             can_issue,
    output logic [cw-1:0]    credits,
    output logic             error
);

    logic [nbits-1:0] entry_reg [nentries];
    logic [pw-1:0]    hd_reg, hd_next;
    logic [pw-1:0]    tl_reg, tl_next;
    logic [cw-1:0]    cnt_reg, cnt_next;
    logic [cw-1:0]    credits_reg, credits_next;
    logic             error_reg, error_next;

    logic full, empty, deq, enq, issue_ok, no_credit;

    always_comb begin
        full      = (cnt_reg == cw'(nentries));
        empty     = (cnt_reg == '0);
        no_credit = (credits_reg == '0);
        deq       = !empty && out_rdy;
        // A dequeue in the same cycle frees the slot, so a full queue may still accept.
        enq       = in_val && (!full || deq);
        issue_ok  = issue && !no_credit;
    end

    always_comb begin
        hd_next = deq ? hd_reg + pw'(1) : hd_reg;
        tl_next = enq ? tl_reg + pw'(1) : tl_reg;

        cnt_next = cnt_reg;
        case ({enq, deq})
            2'b10:   cnt_next = cnt_reg + cw'(1);
            2'b01:   cnt_next = cnt_reg - cw'(1);
            default: cnt_next = cnt_reg;
        endcase

        credits_next = credits_reg;
        case ({issue_ok, deq})
            2'b10:   credits_next = credits_reg - cw'(1);
            2'b01:   credits_next = credits_reg + cw'(1);
            default: credits_next = credits_reg;
        endcase

        error_next = error_reg
                   | (issue && no_credit)
                   | (in_val && full && !deq);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hd_reg      <= '0;
            tl_reg      <= '0;
            cnt_reg     <= '0;
            credits_reg <= cw'(nentries);
            error_reg   <= 1'b0;
        end else begin
            hd_reg      <= hd_next;
            tl_reg      <= tl_next;
            cnt_reg     <= cnt_next;
            credits_reg <= credits_next;
            error_reg   <= error_next;
        end
    end

    // When full with hd==tl the slot being read is rewritten; the read is combinational so it is safe.
    for (genvar gi = 0; gi < nentries; gi++) begin : g_entry
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                entry_reg[gi] <= '0;
            end else if (enq && (tl_reg == pw'(gi))) begin
                entry_reg[gi] <= in_;
            end
        end
    end

    assign out_val   = !empty;
    assign out       = entry_reg[hd_reg];
    assign credits   = credits_reg;
    assign can_issue = !no_credit;
    assign error     = error_reg;

endmodule
